lsu_mem_master: RTL and testbench

//  Load/store initiator between the RV32I execute stage and data_memory (word-only, no byte enables,

---
 rtl/lsu_mem_master.sv | 253 +++++++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
// Load/store initiator between the RV32I execute stage and a word-wide data
// memory with a combinational read port and a synchronous write port. Each
// accepted request becomes one of three word-level operations:
//   - loads (LB/LH/LW/LBU/LHU): one word read, then lane extract and extend
//   - SW: one word write
//   - SB/SH: read-modify-write (word read, lane merge, word write)
// Misaligned, out-of-range and illegal-funct3 requests complete with rsp_err
// and never touch memory.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_we                1 = store, 0 = load
//   req_funct3            RV32I funct3 of the load/store
//   req_addr, req_wdata   byte address and store data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata, rsp_err    load result / error flag, valid with rsp_valid
//   mem_rd_en, mem_wr_en  memory strobes (never both high)
//   mem_addr, mem_wdata   word-aligned address and write data
//   mem_rdata             combinational read data from memory
//
// All outputs come straight from flops: the combinational process computes the
// value each output will hold in the next state, and the state register
// captures it together with the state.
// -----------------------------------------------------------------------------
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LD     = 3'd1,
        ST_WR     = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Request legality: funct3 must exist for the direction, halves need
    // addr[0]=0, words need addr[1:0]=0, and the address must be in range.
    function automatic logic req_is_err(input logic we, input logic [2:0] f3,
                                        input logic [31:0] addr);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            3'b100:  bad = we;
            3'b101:  bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        return bad | (addr >= ADDR_LIMIT);
    endfunction

    // Pick the addressed byte/half out of a little-endian word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                                 input logic [1:0] lane,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {lane, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte (SB) or half (SH) lane of the old word.
    function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                                input logic [1:0] lane,
                                                input logic [31:0] old_word,
                                                input logic [31:0] data);
        logic [31:0] mask;
        logic [31:0] ins;
        case (f3)
            3'b000: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = data << {lane, 3'b000};
            end
            3'b001: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = data << {lane[1], 4'b0000};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = data;
            end
        endcase
        return (old_word & ~mask) | (ins & mask);
    endfunction

    state_t      state_r, state_s;
    logic        req_we_r;
    logic [2:0]  req_funct3_r;
    logic [31:0] req_addr_r;
    logic [31:0] req_wdata_r;
    logic        accept_s;
    logic        req_ready_r, req_ready_s;
    logic        rsp_valid_r, rsp_valid_s;
    logic [31:0] rsp_rdata_r, rsp_rdata_s;
    logic        rsp_err_r, rsp_err_s;
    logic        mem_rd_en_r, mem_rd_en_s;
    logic        mem_wr_en_r, mem_wr_en_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;

    // Next state and next-cycle output values.
    always_comb begin
        state_s     = state_r;
        accept_s    = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_rdata_s = 32'h0000_0000;
        rsp_err_s   = 1'b0;
        mem_rd_en_s = 1'b0;
        mem_wr_en_s = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    accept_s = 1'b1;
                    if (req_is_err(req_we, req_funct3, req_addr)) begin
                        state_s     = ST_RESP;
                        rsp_valid_s = 1'b1;
                        rsp_err_s   = 1'b1;
                    end else if (!req_we) begin
                        state_s     = ST_LD;
                        mem_rd_en_s = 1'b1;
                        mem_addr_s  = {req_addr[31:2], 2'b00};
                    end else if (req_funct3 == 3'b010) begin
                        state_s     = ST_WR;
                        mem_wr_en_s = 1'b1;
                        mem_addr_s  = {req_addr[31:2], 2'b00};
                        mem_wdata_s = req_wdata;
                    end else begin
                        state_s     = ST_RMW_RD;
                        mem_rd_en_s = 1'b1;
                        mem_addr_s  = {req_addr[31:2], 2'b00};
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LD: begin
                // mem_rdata is valid now since mem_addr is already presented.
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
                rsp_rdata_s = load_extract(req_funct3_r, req_addr_r[1:0], mem_rdata);
            end
            ST_WR: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
            end
            ST_RMW_RD: begin
                state_s     = ST_RMW_WR;
                mem_wr_en_s = 1'b1;
                mem_addr_s  = {req_addr_r[31:2], 2'b00};
                mem_wdata_s = store_merge(req_funct3_r, req_addr_r[1:0], mem_rdata, req_wdata_r);
            end
            ST_RMW_WR: begin
                state_s     = ST_RESP;
                rsp_valid_s = 1'b1;
            end
            ST_RESP: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        req_ready_s = (state_s == ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            mem_rd_en_r <= 1'b0;
            mem_wr_en_r <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            mem_rd_en_r <= mem_rd_en_s;
            mem_wr_en_r <= mem_wr_en_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // Request capture at accept; inputs are free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_we_r     <= 1'b0;
            req_funct3_r <= 3'b000;
            req_addr_r   <= 32'h0000_0000;
            req_wdata_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            req_we_r     <= req_we;
            req_funct3_r <= req_funct3;
            req_addr_r   <= req_addr;
            req_wdata_r  <= req_wdata;
        end else begin
            req_we_r     <= req_we_r;
            req_funct3_r <= req_funct3_r;
            req_addr_r   <= req_addr_r;
            req_wdata_r  <= req_wdata_r;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign mem_rd_en = mem_rd_en_r;
    assign mem_wr_en = mem_wr_en_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
// Directed vector table for loads/stores/errors with hand-computed results,
// a reset-during-RMW sequence, and a back-to-back random run against a small
// reference model of memory.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Data memory: combinational read, synchronous write, bench-driven clear.
    logic [31:0] mem [0:255];
    logic        mem_clear;
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_wr_en) begin
            mem[mem_addr[9:2]] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_rd_en && mem_wr_en) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] wword;
        int          lat;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input logic [31:0] ww, input int lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
        v.rdata = rd; v.wword = ww; v.lat = lat;
        return v;
    endfunction

    // Issue one request with a single-cycle req_valid pulse and check the result.
    task automatic run_vec(input int idx, input vec_t v);
        int lat, rd_n, wr_n, exp_rd, exp_wr;
        logic [31:0] wd;
        bit done;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
        req_addr = v.addr; req_wdata = v.wdata;
        lat = 0; rd_n = 0; wr_n = 0; wd = 32'h0; done = 1'b0;
        while (!done && lat < 8) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            req_we = ~v.we; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
            if (mem_rd_en) rd_n++;
            if (mem_wr_en) begin wr_n++; wd = mem_wdata; end
            if (rsp_valid) done = 1'b1;
        end
        exp_rd = (v.lat == 3 || (v.lat == 2 && !v.we)) ? 1 : 0;
        exp_wr = (v.lat >= 2 && v.we) ? 1 : 0;
        chk($sformatf("v%0d rsp_seen", idx), {31'h0, done}, 32'h1);
        chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
        chk($sformatf("v%0d rsp_err", idx), {31'h0, rsp_err}, (v.lat == 1) ? 32'h1 : 32'h0);
        chk($sformatf("v%0d rsp_rdata", idx), rsp_rdata, v.rdata);
        chk($sformatf("v%0d rd_strobes", idx), 32'(rd_n), 32'(exp_rd));
        chk($sformatf("v%0d wr_strobes", idx), 32'(wr_n), 32'(exp_wr));
        if (exp_wr == 1) chk($sformatf("v%0d mem_wdata", idx), wd, v.wword);
        @(negedge clk);
        chk($sformatf("v%0d rsp_pulse", idx), {31'h0, rsp_valid}, 32'h0);
    endtask

    // Reference model for the random run.
    logic [31:0] ref_mem [0:255];

    task automatic ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int size;
        logic [31:0] w;
        logic [7:0] b;
        logic [15:0] h;
        size = 0;
        if (!we) begin
            case (f3)
                3'b000, 3'b100: size = 1;
                3'b001, 3'b101: size = 2;
                3'b010:         size = 4;
                default:        size = 0;
            endcase
        end else begin
            case (f3)
                3'b000:  size = 1;
                3'b001:  size = 2;
                3'b010:  size = 4;
                default: size = 0;
            endcase
        end
        err = (size == 0) || (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00) || (a >= 32'd1024);
        rd = 32'h0;
        if (!err) begin
            w = ref_mem[a[9:2]];
            b = w[8*a[1:0] +: 8];
            h = w[16*a[1] +: 16];
            if (!we) begin
                case (f3)
                    3'b000:  rd = {{24{b[7]}}, b};
                    3'b100:  rd = {24'h0, b};
                    3'b001:  rd = {{16{h[15]}}, h};
                    3'b101:  rd = {16'h0, h};
                    default: rd = w;
                endcase
            end else begin
                if (size == 1) w[8*a[1:0] +: 8] = wd[7:0];
                else if (size == 2) w[16*a[1] +: 16] = wd[15:0];
                else w = wd;
                ref_mem[a[9:2]] = w;
            end
        end
    endtask

    vec_t vecs [0:63];
    int   nv;

    initial begin : main
        logic        e_err;
        logic [31:0] e_rd;
        logic        q_err [$];
        logic [31:0] q_rd  [$];
        int          issued, got, cyc, wr_seen, mism;

        rst_n = 1'b0; mem_clear = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("reset mem_strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1; mem_clear = 1'b0;
        @(negedge clk);
        chk("reset req_ready", {31'h0, req_ready}, 32'h1);

        // we, f3, addr, wdata, expected rdata, expected write word, latency
        nv = 0;
        vecs[nv++] = mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 2);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 32'h11223344, 2);
        vecs[nv++] = mk(1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 32'hA5223344, 3);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFA5, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000A5, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hA5223344, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h10, 32'h11223344, 32'h0, 32'h11223344, 2);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h12, 32'h00008001, 32'h0, 32'h80013344, 3);
        vecs[nv++] = mk(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF8001, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b101, 32'h12, 32'h0, 32'h00008001, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b000, 32'h10, 32'hFFFFFF7E, 32'h0, 32'h8001337E, 3);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h11, 32'h0, 32'h00000033, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b001, 32'h10, 32'h0, 32'h0000337E, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b100, 32'h10, 32'h0, 32'h0000007E, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h10, 32'h0000ABCD, 32'h0, 32'h8001ABCD, 3);
        vecs[nv++] = mk(1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFABCD, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b000, 32'h11, 32'h00000012, 32'h0, 32'h800112CD, 3);
        vecs[nv++] = mk(1'b1, 3'b000, 32'h12, 32'h00000099, 32'h0, 32'h809912CD, 3);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF99, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h02, 32'h0, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b1, 3'b101, 32'h10, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h13, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b0, 3'b001, 32'h3FF, 32'h0, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h400, 32'h0, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h400, 32'hFFFFFFFF, 32'h0, 32'h0, 1);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h10, 32'h0, 32'h809912CD, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h3FC, 32'h12345678, 32'h0, 32'h12345678, 2);
        vecs[nv++] = mk(1'b0, 3'b010, 32'h3FC, 32'h0, 32'h12345678, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b000, 32'h3FF, 32'h0, 32'h00000012, 32'h0, 2);
        vecs[nv++] = mk(1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00001234, 32'h0, 2);
        vecs[nv++] = mk(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 32'h0, 32'hCAFEF00D, 2);
        for (int i = 0; i < nv; i++) run_vec(i, vecs[i]);

        // Reset while the RMW is in its read phase: the write must never happen.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'h00000055;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rmw_rd reached", {31'h0, mem_rd_en}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst strobes", {30'h0, mem_rd_en, mem_wr_en}, 32'h0);
        chk("midrst rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("midrst mem_addr", mem_addr, 32'h0);
        chk("midrst mem_wdata", mem_wdata, 32'h0);
        wr_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr_en || rsp_valid) wr_seen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mem_wr_en || rsp_valid) wr_seen++;
        end
        chk("midrst no_write_no_rsp", 32'(wr_seen), 32'h0);
        chk("midrst req_ready", {31'h0, req_ready}, 32'h1);
        run_vec(100, mk(1'b0, 3'b010, 32'h20, 32'h0, 32'hCAFEF00D, 32'h0, 2));

        // Back-to-back run with req_valid held high.
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        issued = 0; got = 0; cyc = 0;
        @(negedge clk);
        req_valid = 1'b1;
        while ((issued < 40 || got < issued) && cyc < 2000) begin
            if (cyc > 0) @(negedge clk);
            cyc++;
            if (rsp_valid) begin
                if (q_err.size() == 0) begin
                    chk("rand extra_rsp", 32'h1, 32'h0);
                end else begin
                    e_err = q_err.pop_front();
                    e_rd  = q_rd.pop_front();
                    chk($sformatf("rand%0d rsp_err", got), {31'h0, rsp_err}, {31'h0, e_err});
                    chk($sformatf("rand%0d rsp_rdata", got), rsp_rdata, e_rd);
                end
                got++;
            end
            if (req_ready && issued < 40) begin
                req_we = 1'($urandom);
                req_funct3 = 3'($urandom);
                req_addr = 32'($urandom_range(0, 63));
                if ($urandom_range(0, 7) == 0) req_addr = req_addr + 32'h400;
                req_wdata = $urandom;
                ref_exec(req_we, req_funct3, req_addr, req_wdata, e_err, e_rd);
                q_err.push_back(e_err);
                q_rd.push_back(e_rd);
                issued++;
            end else if (req_ready) begin
                req_valid = 1'b0;
            end else begin
                req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        chk("rand issued", 32'(issued), 32'd40);
        chk("rand responses", 32'(got), 32'(issued));
        mism = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("rand memory_words", 32'(mism), 32'h0);
        chk("strobe overlap", 32'(overlap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
